// File: rtl/xor_cipher_pkg.sv
// Shared constants, state encoding and keystream step for the 19-bit XOR cipher path.
package xor_cipher_pkg;

  localparam int          WORD_W    = 19;
  localparam logic [18:0] KEY_SEED  = 19'h1A2B3;
  // Feedback taps at bits 18, 17, 16, 13.
  localparam logic [18:0] LFSR_TAPS = 19'h72000;

  typedef enum logic {IDLE, ACTIVE} state_e;

  function automatic logic [18:0] next_key(input logic [18:0] k);
    return {k[17:0], ^(k & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 19-bit Fibonacci keystream generator; load wins over step. Shared with the encryptor.
module keystream_lfsr
  import xor_cipher_pkg::*;
#(
  parameter logic [18:0] SEED = KEY_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [18:0] key
);

  logic [18:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (load)      key_d = SEED;
    else if (step) key_d = next_key(key_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= SEED;
    else     key_q <= key_d;
  end

  assign key = key_q;

endmodule

// File: rtl/xor_stream_decrypt.sv
// Stream decryptor: ciphertext XOR rolling LFSR keystream, one output register, full throughput.
// Optional in-band parity check enabled by defining XOR_STREAM_PARITY_EN.
module xor_stream_decrypt #(
  parameter int          WORD_W    = xor_cipher_pkg::WORD_W,
  parameter logic [18:0] KEY_SEED  = xor_cipher_pkg::KEY_SEED,
  parameter int          FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef XOR_STREAM_PARITY_EN
  ,
  input  logic              in_parity,
  output logic              parity_err
`endif
);

  import xor_cipher_pkg::*;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic              ol_q, ol_d;
  logic [WORD_W-1:0] od_q, od_d;
  logic [18:0]       key;
  logic              accept, last_word;

  assign in_ready  = (state_q == ACTIVE) && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_word = (cnt_q == 16'(FRAME_LEN - 1));

  keystream_lfsr #(.SEED(KEY_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (start),
    .step (accept),
    .key  (key)
  );

  // start restarts the frame even if a word is accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (start) begin
          cnt_d = '0;
        end else if (accept) begin
          if (last_word) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    ol_d = ol_q;
    if (accept) begin
      ov_d = 1'b1;
      od_d = in_data ^ key;
      ol_d = last_word;
    end else if (out_ready) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign busy      = (state_q == ACTIVE);

`ifdef XOR_STREAM_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (start)                                  perr_d = 1'b0;
    else if (accept && (in_parity != ^in_data)) perr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Randomized bench for xor_stream_decrypt against a transaction-level keystream model.
module tb_xor_stream_decrypt;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [18:0] in_data, out_data;
  logic        in_ready, out_valid, out_last, busy;
`ifdef XOR_STREAM_PARITY_EN
  logic        in_parity, parity_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // model: frame active, word index in frame, pending output word, sticky parity flag
  logic        m_active, m_pv, m_pl, m_err;
  logic [18:0] m_pd;
  int          m_idx;

  always #5 clk = ~clk;

  xor_stream_decrypt #(.FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef XOR_STREAM_PARITY_EN
    ,
    .in_parity (in_parity),
    .parity_err(parity_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // key for word n of a frame: seed advanced n times by the spec polynomial
  function automatic logic [18:0] key_at(input int n);
    logic [18:0] k;
    k = 19'h1A2B3;
    for (int i = 0; i < n; i++) k = {k[17:0], k[18] ^ k[17] ^ k[16] ^ k[13]};
    return k;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef XOR_STREAM_PARITY_EN
    in_parity = 1'b0;
`endif
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_last",  {31'd0, out_last},  0);
    chk("rst_busy",      {31'd0, busy},      0);
    chk("rst_in_ready",  {31'd0, in_ready},  0);
    chk("rst_out_data",  {13'd0, out_data},  0);
`ifdef XOR_STREAM_PARITY_EN
    chk("rst_parity_err", {31'd0, parity_err}, 0);
`endif
    m_active = 0; m_pv = 0; m_pl = 0; m_pd = '0; m_idx = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: drive, check ready/busy, advance model, check registered outputs.
  task automatic step(input logic st, input logic iv, input logic [18:0] d,
                      input logic ordy, input logic pbad);
    logic rdy, acc;
    start = st; in_valid = iv; in_data = d; out_ready = ordy;
`ifdef XOR_STREAM_PARITY_EN
    in_parity = (^d) ^ pbad;
`endif
    #1;
    rdy = m_active && (!m_pv || ordy);
    acc = iv && rdy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("busy",     {31'd0, busy},     {31'd0, m_active});
    if (acc) begin
      m_pd = d ^ key_at(m_idx);
      m_pv = 1'b1;
      m_pl = (m_idx == FL - 1);
      if (pbad) m_err = 1'b1;
    end else if (ordy) begin
      m_pv = 1'b0;
    end
    if (st) begin
      m_active = 1'b1; m_idx = 0; m_err = 1'b0;
    end else if (acc) begin
      if (m_idx == FL - 1) begin m_active = 1'b0; m_idx = 0; end
      else m_idx++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_pv});
    if (m_pv) begin
      chk("out_data", {13'd0, out_data}, {13'd0, m_pd});
      chk("out_last", {31'd0, out_last}, {31'd0, m_pl});
    end
`ifdef XOR_STREAM_PARITY_EN
    chk("parity_err", {31'd0, parity_err}, {31'd0, m_err});
`endif
  endtask

  initial begin
    logic [18:0] d;
    do_reset();

    // all-zero ciphertext exposes the raw keystream
    step(1, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0); chk("key0", {13'd0, out_data}, 32'h1A2B3);
    step(0, 1, 0, 1, 0); chk("key1", {13'd0, out_data}, 32'h34566);
    step(0, 1, 0, 1, 0); chk("key2", {13'd0, out_data}, 32'h68ACC);
    step(0, 1, 19'h55555, 1, 0); chk("last_w4", {31'd0, out_last}, 1);
    // 5th word must not be accepted until the next start
    step(0, 1, 19'h12345, 1, 0); chk("idle_busy", {31'd0, busy}, 0);
    step(0, 1, 19'h12345, 1, 0);
    step(1, 1, 19'h12345, 1, 0);
    step(0, 1, 19'h00000, 1, 0); chk("restart_key0", {13'd0, out_data}, 32'h1A2B3);

    // backpressure: 5 stalled cycles, then the next key must not be skipped
    step(1, 0, 0, 1, 0);
    d = 19'($urandom);
    step(0, 1, d, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 19'($urandom), 0, 0);
    chk("held_data", {13'd0, out_data}, {13'd0, d ^ 19'h1A2B3});
    d = 19'($urandom);
    step(0, 1, d, 1, 0);
    chk("post_stall", {13'd0, out_data}, {13'd0, d ^ 19'h34566});

    // start mid-frame after 2 words
    step(1, 0, 0, 1, 0);
    step(0, 1, 19'($urandom), 1, 0);
    step(0, 1, 19'($urandom), 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 1, 19'h1A2B3, 1, 0); chk("midstart", {13'd0, out_data}, 0);

    // reset with a pending word
    step(1, 0, 0, 1, 0);
    step(0, 1, 19'($urandom), 0, 0);
    do_reset();
    step(1, 0, 0, 1, 0);
    step(0, 1, 19'h00000, 1, 0); chk("post_rst_key", {13'd0, out_data}, 32'h1A2B3);

`ifdef XOR_STREAM_PARITY_EN
    step(1, 0, 0, 1, 0);
    step(0, 1, 19'h00001, 1, 1); chk("perr_set", {31'd0, parity_err}, 1);
    step(0, 1, 19'h00003, 1, 0);
    step(0, 1, 19'h00007, 1, 0); chk("perr_sticky", {31'd0, parity_err}, 1);
    step(1, 0, 0, 1, 0);          chk("perr_clear", {31'd0, parity_err}, 0);
`endif

    // randomized traffic with occasional restarts and parity errors
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 19) == 0) || (!m_active && $urandom_range(0, 3) == 0),
           1'($urandom), 19'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
